fma_issue_seq: RTL

//  Issue/collect sequencer that drives the fused multiply-add pipe (fmas) from a valid/ready operand stream.

---
 rtl/fma_issue_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/fma_issue_seq.sv
// Issue/collect sequencer for the fused multiply-add pipe: applies sign variants, issues on credits, and
// captures results at fixed latency into a result FIFO. Optional sticky flags under FMA_FFLAGS_EN.
module fma_issue_seq #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic [31:0] in_z,
    output logic        fma_req,
    output logic [31:0] fma_x,
    output logic [31:0] fma_y,
    output logic [31:0] fma_z,
    input  logic [31:0] fma_rslt,
    input  logic [4:0]  fma_flag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rslt,
    output logic [4:0]  out_flag,
    output logic [4:0]  fflags,
    input  logic        fflags_clr
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + LAT + 1);

    typedef struct packed {
        logic [4:0]  flag;
        logic [31:0] rslt;
    } res_t;

    logic [LAT-1:0] vld_sr;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  inflight;
    res_t           mem [DEPTH];
    res_t           head;
    logic           issue, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + CW'(vld_sr[i]);
    end

    // Credits: every in-flight op already owns a FIFO slot, so a landing result never finds it full.
    assign in_ready = ~reset & ((inflight + cnt_q) < CW'(DEPTH));
    assign issue    = in_valid & in_ready;
    assign fma_req  = issue;

    // op[1] negates the product (x sign), op[0] negates the addend (z sign).
    assign fma_x = {in_x[31] ^ in_op[1], in_x[30:0]};
    assign fma_y = in_y;
    assign fma_z = {in_z[31] ^ in_op[0], in_z[30:0]};

    assign push = vld_sr[LAT-1];

    // An empty FIFO shows the landing result directly, so a result is visible the cycle it arrives.
    assign head      = (cnt_q == '0) ? res_t'({fma_flag, fma_rslt}) : mem[rd_ptr];
    assign out_valid = ~reset & (push | (cnt_q != '0));
    assign out_rslt  = head.rslt;
    assign out_flag  = head.flag;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < LAT; i++) vld_sr[i] <= vld_sr[i-1];
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= res_t'({fma_flag, fma_rslt});
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && cnt_q == CW'(DEPTH)));
    end

`ifdef FMA_FFLAGS_EN
    logic [4:0] fflags_q;

    // A pop in the clear cycle leaves exactly that pop's flags behind.
    always_ff @(posedge clk) begin
        if (reset)           fflags_q <= '0;
        else if (pop)        fflags_q <= fflags_clr ? out_flag : (fflags_q | out_flag);
        else if (fflags_clr) fflags_q <= '0;
    end

    assign fflags = fflags_q;
`else
    logic unused_fflags_clr;

    assign unused_fflags_clr = fflags_clr;
    assign fflags            = 5'h0;
`endif

endmodule
